// File: rtl/rle_pkg.sv
// Shared constants for the RLE code scheduler: default code width, channel tags, FSM encoding.
package rle_pkg;

    localparam int unsigned CODE_W_DEF = 16;

    localparam logic [1:0] CH_R = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

endpackage

// File: rtl/rle_code_fifo.sv
// Synchronous FIFO of packed code triples; a push at full succeeds when a pop happens in the same cycle.
module rle_code_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: rtl/rle_code_sched.sv
// Buffers R/G/B encoder code triples and serializes them as tagged beats, one frame per start.
// Optional frame statistics (trip_cnt, drop_cnt) are built when RLE_SCHED_STATS_EN is defined.
module rle_code_sched
    import rle_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CODE_W = CODE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              nr,
    input  logic [CODE_W-1:0] r_code,
    input  logic [CODE_W-1:0] g_code,
    input  logic [CODE_W-1:0] b_code,
    input  logic              enc_done,
    output logic              enc_rst,
    output logic [CODE_W-1:0] out_code,
    output logic [1:0]        out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
`ifdef RLE_SCHED_STATS_EN
    ,
    output logic [15:0]       trip_cnt,
    output logic [7:0]        drop_cnt
`endif
);

    localparam int unsigned TW = 3 * CODE_W;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    state_e         state_q, state_d;
    logic [1:0]     ch_q, ch_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q, busy_d;
    logic           enc_rst_q, enc_rst_d;
    logic           frame_done_q, frame_done_d;
    logic           overflow_q, overflow_d;

    logic           push;
    logic           pop;
    logic           drop;
    logic           clr;
    logic           accept;
    logic [CW-1:0]  count_d;

    logic [TW-1:0]  fifo_din;
    logic [TW-1:0]  head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;

    assign fifo_din = {r_code, g_code, b_code};

    rle_code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state, beat sequencing and FIFO control.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        overflow_d   = overflow_q;
        push         = 1'b0;
        pop          = 1'b0;
        drop         = 1'b0;
        clr          = 1'b0;
        accept       = out_valid_q && out_ready;

        if (accept) begin
            if (ch_q == CH_B) begin
                ch_d = CH_R;
                pop  = 1'b1;
            end else begin
                ch_d = ch_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    clr     = 1'b1;
                end
            end
            ST_RUN: begin
                if (nr) begin
                    if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (enc_done) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clr) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end

        // Outputs are registered from the post-edge state and occupancy.
        count_d      = fifo_count + CW'(push) - CW'(pop);
        busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        out_valid_d  = busy_d && (count_d != '0);
        enc_rst_d    = !busy_d;
        frame_done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= CH_R;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            enc_rst_q    <= 1'b1;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
            enc_rst_q    <= enc_rst_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Beat data is a pure select of registered head and channel; forced to zero when idle.
    always_comb begin
        out_code = '0;
        if (out_valid_q) begin
            case (ch_q)
                CH_R:    out_code = head[TW-1 -: CODE_W];
                CH_G:    out_code = head[2*CODE_W-1 -: CODE_W];
                default: out_code = head[CODE_W-1:0];
            endcase
        end
    end

    assign out_last   = out_valid_q && (ch_q == CH_B) && (state_q == ST_DRAIN)
                        && (fifo_count == CW'(1));
    assign out_valid  = out_valid_q;
    assign out_ch     = ch_q;
    assign busy       = busy_q;
    assign enc_rst    = enc_rst_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

`ifdef RLE_SCHED_STATS_EN
    logic [15:0] trip_cnt_q, trip_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    // Per-frame triple and drop counters; drop count saturates.
    always_comb begin
        trip_cnt_d = trip_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            trip_cnt_d = '0;
            drop_cnt_d = '0;
        end else begin
            if (pop) begin
                trip_cnt_d = trip_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trip_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            trip_cnt_q <= trip_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign trip_cnt = trip_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule
